// File: rtl/kernel_job_scheduler.sv
// Kernel job scheduler: a FIFO of 64-bit job descriptors dispatched
// round-robin onto a pool of kernels. It tracks per-kernel busy state
// from completion edges and keeps dispatch and completion counters.
module kernel_job_scheduler #(
   parameter int KERNEL_NUM = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  soft_clear,
   input  logic                  job_valid,
   input  logic [63:0]           job_addr,
   output logic                  job_ready,
   output logic [KERNEL_NUM-1:0] kernel_start,
   output logic [63:0]           kernel_job_addr,
   input  logic [KERNEL_NUM-1:0] kernel_complete,
   output logic [KERNEL_NUM-1:0] kernel_busy,
   output logic [LW-1:0]         fifo_level,
   output logic                  idle,
   output logic [31:0]           jobs_dispatched,
   output logic [31:0]           jobs_completed
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int KW = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_e;

   // One-hot decode of a kernel index.
   function automatic logic [KERNEL_NUM-1:0] onehot(input logic [KW-1:0] idx);
      logic [KERNEL_NUM-1:0] v;
      for (int i = 0; i < KERNEL_NUM; i++) begin
         v[i] = (KW'(i) == idx);
      end
      return v;
   endfunction

   // Number of set bits in a per-kernel vector, widened to counter width.
   function automatic logic [31:0] popcount(input logic [KERNEL_NUM-1:0] v);
      logic [31:0] n;
      n = 32'd0;
      for (int i = 0; i < KERNEL_NUM; i++) begin
         n = n + {31'd0, v[i]};
      end
      return n;
   endfunction

   state_e                state_q, state_d;
   logic [63:0]           mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic [KW-1:0]         last_grant_q, last_grant_d;
   logic [KERNEL_NUM-1:0] start_q, start_d;
   logic [63:0]           addr_q, addr_d;
   logic [KERNEL_NUM-1:0] busy_q, busy_d;
   logic [KERNEL_NUM-1:0] prev_q;
   logic [31:0]           disp_q, disp_d;
   logic [31:0]           comp_q, comp_d;

   logic                  full_s;
   logic                  empty_s;
   logic                  push_s;
   logic                  go_s;
   logic                  any_free_s;
   logic [KW-1:0]         grant_s;
   logic                  grant_found_s;
   logic [KW-1:0]         cand_s;
   int                    scan_s;
   logic [KERNEL_NUM-1:0] edge_s;
   logic [KERNEL_NUM-1:0] counted_s;

   assign full_s     = (level_q == LW'(FIFO_DEPTH));
   assign empty_s    = (level_q == LW'(0));
   assign any_free_s = ~(&busy_q);
   assign push_s     = job_valid & ~full_s & ~soft_clear;
   // Only genuine completions of dispatched work clear busy and are counted.
   assign edge_s     = kernel_complete & ~prev_q;
   assign counted_s  = edge_s & busy_q;

   assign job_ready       = ~full_s;
   assign kernel_start    = start_q;
   assign kernel_job_addr = addr_q;
   assign kernel_busy     = busy_q;
   assign fifo_level      = level_q;
   assign jobs_dispatched = disp_q;
   assign jobs_completed  = comp_q;
   assign idle            = empty_s & ~(|busy_q) & (state_q == ST_IDLE);

   // Round-robin scan for the first free kernel after the last grant.
   always_comb begin
      grant_s       = last_grant_q;
      grant_found_s = 1'b0;
      scan_s        = 0;
      cand_s        = last_grant_q;
      for (int i = 1; i <= KERNEL_NUM; i++) begin
         scan_s = (int'(last_grant_q) + i) % KERNEL_NUM;
         cand_s = KW'(scan_s);
         if (!grant_found_s && !busy_q[cand_s]) begin
            grant_s       = cand_s;
            grant_found_s = 1'b1;
         end else begin
            grant_s       = grant_s;
            grant_found_s = grant_found_s;
         end
      end
   end

   // FSM next state; a dispatch decision is taken only from IDLE.
   always_comb begin
      state_d = state_q;
      go_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable && !empty_s && any_free_s && !soft_clear) begin
               go_s    = 1'b1;
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Queue pointer and level update; soft_clear flushes, overriding push.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (soft_clear) begin
         wr_ptr_d = AW'(0);
         rd_ptr_d = AW'(0);
         level_d  = LW'(0);
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (go_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, go_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // Queue pointer and level registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= AW'(0);
         rd_ptr_q <= AW'(0);
         level_q  <= LW'(0);
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Descriptor storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= job_addr;
      end
   end

   // Dispatch outputs: one-cycle start pulse, held address, last grant.
   always_comb begin
      start_d      = {KERNEL_NUM{1'b0}};
      addr_d       = addr_q;
      last_grant_d = last_grant_q;
      if (go_s) begin
         start_d      = onehot(grant_s);
         addr_d       = mem_q[rd_ptr_q];
         last_grant_d = grant_s;
      end else begin
         start_d      = {KERNEL_NUM{1'b0}};
      end
   end

   // Dispatch output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q      <= {KERNEL_NUM{1'b0}};
         addr_q       <= 64'd0;
         last_grant_q <= KW'(KERNEL_NUM - 1);
      end else begin
         start_q      <= start_d;
         addr_q       <= addr_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Busy tracking: completions clear, a grant sets (grant wins on overlap).
   always_comb begin
      busy_d = busy_q & ~counted_s;
      if (go_s) begin
         busy_d = busy_d | onehot(grant_s);
      end else begin
         busy_d = busy_d;
      end
   end

   // Busy and completion-history registers; history starts high so a level
   // already present at reset is not taken as a completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= {KERNEL_NUM{1'b0}};
         prev_q <= {KERNEL_NUM{1'b1}};
      end else begin
         busy_q <= busy_d;
         prev_q <= kernel_complete;
      end
   end

   // Counter next values; wrap naturally at 32 bits.
   always_comb begin
      disp_d = disp_q;
      comp_d = comp_q;
      if (soft_clear) begin
         disp_d = 32'd0;
         comp_d = 32'd0;
      end else begin
         if (go_s) begin
            disp_d = disp_q + 32'd1;
         end else begin
            disp_d = disp_q;
         end
         comp_d = comp_q + popcount(counted_s);
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_q <= 32'd0;
         comp_q <= 32'd0;
      end else begin
         disp_q <= disp_d;
         comp_q <= comp_d;
      end
   end

endmodule

// File: tb/tb_kernel_job_scheduler.sv
// Self-checking bench for kernel_job_scheduler: directed scenarios plus
// randomized traffic, all compared cycle by cycle against a queue-based
// reference model.
module tb_kernel_job_scheduler;

   localparam int K  = 8;
   localparam int D  = 8;
   localparam int LW = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          soft_clear;
   logic          job_valid;
   logic [63:0]   job_addr;
   logic          job_ready;
   logic [K-1:0]  kernel_start;
   logic [63:0]   kernel_job_addr;
   logic [K-1:0]  kernel_complete;
   logic [K-1:0]  kernel_busy;
   logic [LW-1:0] fifo_level;
   logic          idle;
   logic [31:0]   jobs_dispatched;
   logic [31:0]   jobs_completed;

   kernel_job_scheduler #(.KERNEL_NUM(K), .FIFO_DEPTH(D)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .enable          (enable),
      .soft_clear      (soft_clear),
      .job_valid       (job_valid),
      .job_addr        (job_addr),
      .job_ready       (job_ready),
      .kernel_start    (kernel_start),
      .kernel_job_addr (kernel_job_addr),
      .kernel_complete (kernel_complete),
      .kernel_busy     (kernel_busy),
      .fifo_level      (fifo_level),
      .idle            (idle),
      .jobs_dispatched (jobs_dispatched),
      .jobs_completed  (jobs_completed)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic [63:0] m_q[$];
   bit [K-1:0]  m_busy;
   bit [K-1:0]  m_prev;
   int          m_last;
   bit          m_issue;
   bit [K-1:0]  m_start;
   logic [63:0] m_addr;
   bit [31:0]   m_disp;
   bit [31:0]   m_comp;
   bit          m_pushed;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_busy  = '0;
      m_prev  = '1;
      m_last  = K - 1;
      m_issue = 1'b0;
      m_start = '0;
      m_addr  = 64'd0;
      m_disp  = 32'd0;
      m_comp  = 32'd0;
   endtask

   task automatic check_all();
      check_eq("kernel_start",    64'(kernel_start),    64'(m_start));
      check_eq("kernel_job_addr", kernel_job_addr,      m_addr);
      check_eq("kernel_busy",     64'(kernel_busy),     64'(m_busy));
      check_eq("fifo_level",      64'(fifo_level),      64'(m_q.size()));
      check_eq("job_ready",       64'(job_ready),       64'(m_q.size() < D));
      check_eq("idle",            64'(idle),            64'(m_q.size() == 0 && m_busy == '0 && !m_issue));
      check_eq("jobs_dispatched", 64'(jobs_dispatched), 64'(m_disp));
      check_eq("jobs_completed",  64'(jobs_completed),  64'(m_comp));
   endtask

   // One clock: predict from current inputs, clock, then compare everything.
   task automatic step();
      bit          push, go, clr;
      int          g;
      bit [K-1:0]  cc, counted, nb;
      logic [63:0] a;
      clr     = soft_clear;
      push    = job_valid && (m_q.size() < D) && !clr;
      go      = !m_issue && enable && (m_q.size() != 0) && (m_busy != '1) && !clr;
      g       = -1;
      for (int i = 1; i <= K; i++) begin
         int k = (m_last + i) % K;
         if (g < 0 && !m_busy[k]) g = k;
      end
      cc      = kernel_complete;
      a       = job_addr;
      counted = cc & ~m_prev & m_busy;
      @(posedge clk);
      #1;
      m_prev = cc;
      nb     = m_busy & ~counted;
      if (go) begin
         m_addr  = m_q.pop_front();
         nb[g]   = 1'b1;
         m_last  = g;
         m_start = '0;
         m_start[g] = 1'b1;
         m_disp  = m_disp + 32'd1;
      end else begin
         m_start = '0;
      end
      m_busy   = nb;
      m_issue  = go;
      m_pushed = push;
      if (push) m_q.push_back(a);
      m_comp = m_comp + 32'($countones(counted));
      if (clr) begin
         m_q.delete();
         m_disp = 32'd0;
         m_comp = 32'd0;
      end
      check_all();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      bit [31:0] c0;
      rst_n           = 1'b0;
      enable          = 1'b0;
      soft_clear      = 1'b0;
      job_valid       = 1'b0;
      job_addr        = 64'd0;
      kernel_complete = '0;
      model_reset();
      #22;
      rst_n = 1'b1;
      step();

      // Three jobs with enable high: starts 0x01/0x02/0x04, two cycles apart.
      enable = 1'b1;
      job_valid = 1'b1; job_addr = 64'h1000; step();
      job_addr = 64'h2000; step();
      job_addr = 64'h3000; step();
      job_valid = 1'b0;
      steps(6);
      check_eq("req035_dispatched", 64'(jobs_dispatched), 64'd3);
      kernel_complete = 8'h07; step();
      kernel_complete = 8'h00; step();

      // Nine pushes with dispatch disabled: eight accepted, ninth held.
      enable = 1'b0;
      job_valid = 1'b1;
      for (int n = 0; n < 9; n++) begin
         job_addr = 64'hA000 + 64'(n);
         step();
      end
      check_eq("req036_ready_full", 64'(job_ready), 64'd0);
      check_eq("req036_level_full", 64'(fifo_level), 64'd8);
      enable = 1'b1;
      m_pushed = 1'b0;
      for (int n = 0; n < 6 && !m_pushed; n++) step();
      check_eq("req036_ninth_taken", 64'(m_pushed), 64'd1);
      job_valid = 1'b0;
      steps(20);
      check_eq("req037_all_busy", 64'(kernel_busy), 64'hFF);

      // Kernel 5 finishes; the queued job must go to it.
      kernel_complete = 8'h20; step();
      for (int n = 0; n < 10 && m_start == '0; n++) step();
      check_eq("req037_start", 64'(kernel_start), 64'h20);
      steps(2);

      // Simultaneous completions on 1, 3, 6 counted together.
      c0 = m_comp;
      kernel_complete = 8'h6A; step();
      check_eq("req038_plus3", 64'(jobs_completed), 64'(c0 + 32'd3));
      kernel_complete = 8'h20; step();
      kernel_complete = 8'hA0; step();
      kernel_complete = 8'h20; step();
      c0 = m_comp;
      kernel_complete = 8'hA0; step();
      check_eq("req038_idle_edge", 64'(jobs_completed), 64'(c0));

      // Soft clear with four queued jobs and nonzero counters.
      enable = 1'b0;
      job_valid = 1'b1;
      for (int n = 0; n < 4; n++) begin
         job_addr = 64'hB000 + 64'(n);
         step();
      end
      soft_clear = 1'b1; step();
      soft_clear = 1'b0; job_valid = 1'b0;
      check_eq("req039_level", 64'(fifo_level), 64'd0);
      check_eq("req039_disp",  64'(jobs_dispatched), 64'd0);
      check_eq("req039_comp",  64'(jobs_completed), 64'd0);
      step();

      // Reset asserted while a start pulse is on the outputs.
      enable = 1'b1;
      job_valid = 1'b1; job_addr = 64'hC0DE; step();
      job_valid = 1'b0;
      for (int n = 0; n < 10 && m_start == '0; n++) step();
      check_eq("req040_pre_start", 64'(kernel_start), 64'h40);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("req040_start_drop", 64'(kernel_start), 64'd0);
      check_eq("req040_busy",       64'(kernel_busy), 64'd0);
      check_eq("req040_level",      64'(fifo_level), 64'd0);
      check_eq("req040_addr",       kernel_job_addr, 64'd0);
      check_eq("req040_disp",       64'(jobs_dispatched), 64'd0);
      #3;
      rst_n = 1'b1;
      #1;
      check_eq("req040_idle",  64'(idle), 64'd1);
      check_eq("req040_ready", 64'(job_ready), 64'd1);
      kernel_complete = '0;
      step();

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         enable     = ($urandom_range(9) != 0);
         soft_clear = ($urandom_range(49) == 0);
         job_valid  = ($urandom_range(1) == 1);
         job_addr   = {$urandom, $urandom};
         for (int b = 0; b < K; b++) begin
            if ($urandom_range(5) == 0) kernel_complete[b] = ~kernel_complete[b];
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/kernel_job_scheduler.md
KERNEL_JOB_SCHEDULER -- requirements
Module: kernel_job_scheduler

Interface
REQ-001 SHALL have parameter KERNEL_NUM, default 8, number of kernels scheduled.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, job queue entries (power of 2).
REQ-003 SHALL have parameter LW, default $clog2(FIFO_DEPTH)+1, width of fifo_level.
REQ-004 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: enable  input  1  level; dispatch permitted while high.
REQ-007 SHALL have port: soft_clear  input  1  synchronous pulse; flush queue and counters.
REQ-008 SHALL have port: job_valid  input  1  job descriptor offered.
REQ-009 SHALL have port: job_addr  input  64  job descriptor address.
REQ-010 SHALL have port: job_ready  output  1  queue can accept a job.
REQ-011 SHALL have port: kernel_start  output  KERNEL_NUM  one-hot one-cycle start pulse.
REQ-012 SHALL have port: kernel_job_addr  output  64  address for started kernel; valid with kernel_start.
REQ-013 SHALL have port: kernel_complete  input  KERNEL_NUM  per-kernel done level; rising edge = job finished.
REQ-014 SHALL have port: kernel_busy  output  KERNEL_NUM  kernel holds a dispatched, unfinished job.
REQ-015 SHALL have port: fifo_level  output  LW  queued job count.
REQ-016 SHALL have port: idle  output  1  queue empty, no kernel busy, FSM in IDLE.
REQ-017 SHALL have port: jobs_dispatched  output  32  dispatch count.
REQ-018 SHALL have port: jobs_completed  output  32  completion count.

Function
REQ-019 SHALL accept a job when job_valid & job_ready; job_ready = !full, combinational from registered level.
REQ-020 SHALL keep the queue FIFO-ordered; a push and pop in the same cycle leave fifo_level unchanged.
REQ-021 SHALL implement FSM IDLE/ISSUE: IDLE->ISSUE when enable & !empty & any kernel not busy & !soft_clear; ISSUE->IDLE unconditionally.
REQ-022 On IDLE->ISSUE: pop head, register grant and head address, set kernel_busy[grant], increment jobs_dispatched.
REQ-023 SHALL drive kernel_start = one-hot grant only in ISSUE (exactly one cycle), else 0; kernel_job_addr holds last grant's address.
REQ-024 SHALL dispatch at most one job per 2 cycles.
REQ-025 SHALL select grant round-robin: first non-busy index scanning from last_grant+1 modulo KERNEL_NUM; last_grant updated to grant; reset value KERNEL_NUM-1.
REQ-026 SHALL detect completion edge per kernel as kernel_complete[i] & !prev[i]; prev reset value all ones.
REQ-027 SHALL clear kernel_busy[i] on a completion edge only if busy; edges on non-busy kernels ignored and not counted.
REQ-028 SHALL add the popcount of counted completion edges to jobs_completed in one cycle (simultaneous completions all counted).
REQ-029 If a grant and a completion edge hit the same kernel in one cycle, busy SHALL be set (edge ignored, kernel was not busy).
REQ-030 Counters SHALL wrap modulo 2^32.
REQ-031 enable low SHALL block new IDLE->ISSUE only; an ISSUE in progress completes; queue still accepts jobs.
REQ-032 soft_clear SHALL empty the queue, zero both counters, ignore a same-cycle push; it SHALL NOT alter kernel_busy, last_grant or an ISSUE in progress.

Reset
REQ-033 On rst_n low: FSM IDLE, queue empty, fifo_level 0, job_ready 1 after release, kernel_start 0, kernel_job_addr 0, kernel_busy 0, counters 0, last_grant KERNEL_NUM-1, prev all ones, idle 1.
REQ-034 Reset asserted mid-ISSUE SHALL drop kernel_start immediately and discard queued jobs.

Verification
REQ-035 enable=1, push 0x1000,0x2000,0x3000 -> kernel_start 0x01,0x02,0x04 with matching addrs, 2 cycles apart; jobs_dispatched=3.
REQ-036 Push 9 jobs with enable=0 -> 8 accepted, job_ready=0 at level 8, 9th held until a pop.
REQ-037 All 8 kernels busy, 1 queued; raise kernel_complete[5] -> busy[5] clears, next start 0x20.
REQ-038 Kernels 1,3,6 complete edges same cycle -> jobs_completed +3 in one cycle; edge on idle kernel 7 -> no count.
REQ-039 soft_clear with level 4, counters nonzero -> level 0, counters 0, busy unchanged.
REQ-040 Reset asserted during ISSUE -> kernel_start 0 same cycle, all REQ-033 values, idle=1 after release.
